// File: rtl/out_vc_credit_tracker_if.sv
// Bus between the output-VC credit tracker and its neighbours (ctrl_web
// credit returns, VC/switch allocator requests, and tracker status back).
interface out_vc_credit_tracker_if #(
   parameter int unsigned NUM_OUT = 4,
   parameter int unsigned NUM_VCS = 4,
   parameter int unsigned CNT_W   = 3
);
   localparam int unsigned VC_W = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;

   logic [NUM_OUT-1:0][NUM_VCS-1:0]            in_credit;
   logic [NUM_OUT-1:0][NUM_VCS-1:0]            alloc_valid;
   logic [NUM_OUT-1:0]                         send_valid;
   logic [NUM_OUT-1:0][VC_W-1:0]               send_vc;
   logic [NUM_OUT-1:0]                         send_tail;
   logic [NUM_OUT-1:0][NUM_VCS-1:0]            vc_free;
   logic [NUM_OUT-1:0][NUM_VCS-1:0]            credit_avail;
   logic [NUM_OUT-1:0][NUM_VCS-1:0][CNT_W-1:0] credit_cnt;
   logic [NUM_OUT-1:0][NUM_VCS-1:0]            credit_err;

   // Allocator / credit-source side
   modport master (
      output in_credit, alloc_valid, send_valid, send_vc, send_tail,
      input  vc_free, credit_avail, credit_cnt, credit_err
   );

   // Tracker side
   modport slave (
      input  in_credit, alloc_valid, send_valid, send_vc, send_tail,
      output vc_free, credit_avail, credit_cnt, credit_err
   );
endinterface

// File: rtl/out_vc_credit_tracker.sv
// Per-output-port, per-VC downstream credit counter and VC ownership FSM.
// Optional macro OUT_VC_CREDIT_ERR_CHK_EN: saturating counters, sticky
// credit_err flags and simulation assertions on illegal allocations.
module out_vc_credit_tracker #(
   parameter int unsigned NUM_OUT   = 4,
   parameter int unsigned NUM_VCS   = 4,
   parameter int unsigned BUF_DEPTH = 4,
   parameter int unsigned CNT_W     = $clog2(BUF_DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   out_vc_credit_tracker_if.slave   bus
);
   localparam int unsigned VC_W = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_WAIT   = 2'd2
   } vc_state_e;

   vc_state_e                                  r_state [NUM_OUT][NUM_VCS];
   logic [NUM_OUT-1:0][NUM_VCS-1:0][CNT_W-1:0] r_cnt;
   logic [NUM_OUT-1:0][NUM_VCS-1:0][CNT_W-1:0] w_cnt_nxt;
   logic [NUM_OUT-1:0][NUM_VCS-1:0]            w_inc;
   logic [NUM_OUT-1:0][NUM_VCS-1:0]            w_dec;
   logic [NUM_OUT-1:0][NUM_VCS-1:0]            w_vc_free;
   logic [NUM_OUT-1:0][NUM_VCS-1:0]            w_avail;
`ifdef OUT_VC_CREDIT_ERR_CHK_EN
   logic [NUM_OUT-1:0][NUM_VCS-1:0]            w_ovf;
   logic [NUM_OUT-1:0][NUM_VCS-1:0]            w_udf;
   logic [NUM_OUT-1:0][NUM_VCS-1:0]            r_err;
`endif

   // Decode credit events and compute next credit count per (port, VC)
   always_comb begin
      w_cnt_nxt = r_cnt;
      w_inc     = '0;
      w_dec     = '0;
`ifdef OUT_VC_CREDIT_ERR_CHK_EN
      w_ovf     = '0;
      w_udf     = '0;
`endif
      for (int p = 0; p < int'(NUM_OUT); p++) begin
         for (int v = 0; v < int'(NUM_VCS); v++) begin
            w_inc[p][v] = bus.in_credit[p][v];
            w_dec[p][v] = bus.send_valid[p] && (bus.send_vc[p] == VC_W'(v));
            if (w_inc[p][v] && !w_dec[p][v]) begin
`ifdef OUT_VC_CREDIT_ERR_CHK_EN
               if (r_cnt[p][v] == FULL) w_ovf[p][v] = 1'b1;
               else                     w_cnt_nxt[p][v] = r_cnt[p][v] + CNT_W'(1);
`else
               w_cnt_nxt[p][v] = r_cnt[p][v] + CNT_W'(1);
`endif
            end else if (w_dec[p][v] && !w_inc[p][v]) begin
`ifdef OUT_VC_CREDIT_ERR_CHK_EN
               if (r_cnt[p][v] == '0) w_udf[p][v] = 1'b1;
               else                   w_cnt_nxt[p][v] = r_cnt[p][v] - CNT_W'(1);
`else
               w_cnt_nxt[p][v] = r_cnt[p][v] - CNT_W'(1);
`endif
            end
         end
      end
   end

   // Credit counters and VC ownership FSM; a VC returns to IDLE only once
   // its downstream buffer is fully drained (count back at BUF_DEPTH)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int p = 0; p < int'(NUM_OUT); p++) begin
            for (int v = 0; v < int'(NUM_VCS); v++) begin
               r_cnt[p][v]   <= FULL;
               r_state[p][v] <= ST_IDLE;
            end
         end
      end else begin
         r_cnt <= w_cnt_nxt;
         for (int p = 0; p < int'(NUM_OUT); p++) begin
            for (int v = 0; v < int'(NUM_VCS); v++) begin
               case (r_state[p][v])
                  ST_IDLE: begin
                     if (bus.alloc_valid[p][v]) r_state[p][v] <= ST_ACTIVE;
                  end
                  ST_ACTIVE: begin
                     if (w_dec[p][v] && bus.send_tail[p])
                        r_state[p][v] <= (w_cnt_nxt[p][v] == FULL) ? ST_IDLE : ST_WAIT;
                  end
                  ST_WAIT: begin
                     if (w_cnt_nxt[p][v] == FULL) r_state[p][v] <= ST_IDLE;
                  end
                  default: r_state[p][v] <= ST_IDLE;
               endcase
            end
         end
      end
   end

`ifdef OUT_VC_CREDIT_ERR_CHK_EN
   // Sticky over/underflow flags, cleared only by reset
   always_ff @(posedge clk) begin
      if (!rst_n) r_err <= '0;
      else        r_err <= r_err | w_ovf | w_udf;
   end

`ifndef SYNTHESIS
   // Allocating a VC that is still owned or draining is an allocator bug
   always_ff @(posedge clk) begin
      if (rst_n) begin
         for (int p = 0; p < int'(NUM_OUT); p++) begin
            for (int v = 0; v < int'(NUM_VCS); v++) begin
               a_alloc_idle: assert (!(bus.alloc_valid[p][v] && (r_state[p][v] != ST_IDLE)))
                  else $error("alloc_valid to non-IDLE VC port %0d vc %0d", p, v);
            end
         end
      end
   end
`endif

   assign bus.credit_err = r_err;
`else
   assign bus.credit_err = '0;
`endif

   // Status decodes of registered state only
   always_comb begin
      w_vc_free = '0;
      w_avail   = '0;
      for (int p = 0; p < int'(NUM_OUT); p++) begin
         for (int v = 0; v < int'(NUM_VCS); v++) begin
            w_vc_free[p][v] = (r_state[p][v] == ST_IDLE);
            w_avail[p][v]   = (r_cnt[p][v] != '0);
         end
      end
   end

   assign bus.vc_free      = w_vc_free;
   assign bus.credit_avail = w_avail;
   assign bus.credit_cnt   = r_cnt;

endmodule

// File: tb/tb_out_vc_credit_tracker.sv
// Directed bench for out_vc_credit_tracker (default parameters, BUF_DEPTH=4).
module tb_out_vc_credit_tracker;
   localparam int unsigned NUM_OUT   = 4;
   localparam int unsigned NUM_VCS   = 4;
   localparam int unsigned BUF_DEPTH = 4;
   localparam int unsigned CNT_W     = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   out_vc_credit_tracker_if #(.NUM_OUT(NUM_OUT), .NUM_VCS(NUM_VCS), .CNT_W(CNT_W)) u_if ();

   out_vc_credit_tracker #(
      .NUM_OUT(NUM_OUT), .NUM_VCS(NUM_VCS), .BUF_DEPTH(BUF_DEPTH), .CNT_W(CNT_W)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      u_if.in_credit   = '0;
      u_if.alloc_valid = '0;
      u_if.send_valid  = '0;
      u_if.send_vc     = '0;
      u_if.send_tail   = '0;
   endtask

   task automatic drive_send(input int p, input int v, input logic tail);
      u_if.send_valid[p] = 1'b1;
      u_if.send_vc[p]    = 2'(v);
      u_if.send_tail[p]  = tail;
   endtask

   task automatic test_reset;
      idle_inputs();
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      checks++; if (u_if.credit_cnt !== {16{3'd4}}) begin errors++;
         $display("FAIL reset_cnt got=%h exp=%h", u_if.credit_cnt, {16{3'd4}}); end
      checks++; if (u_if.vc_free !== 16'hFFFF) begin errors++;
         $display("FAIL reset_vc_free got=%h exp=ffff", u_if.vc_free); end
      checks++; if (u_if.credit_avail !== 16'hFFFF) begin errors++;
         $display("FAIL reset_avail got=%h exp=ffff", u_if.credit_avail); end
      checks++; if (u_if.credit_err !== 16'h0000) begin errors++;
         $display("FAIL reset_err got=%h exp=0000", u_if.credit_err); end
   endtask

   task automatic test_fill;
      u_if.alloc_valid[1][2] = 1'b1;
      tick(); idle_inputs();
      checks++; if (u_if.vc_free[1][2] !== 1'b0) begin errors++;
         $display("FAIL fill_alloc_vc_free got=%b exp=0", u_if.vc_free[1][2]); end
      for (int i = 0; i < 4; i++) begin
         drive_send(1, 2, 1'b0);
         tick(); idle_inputs();
         checks++; if (u_if.credit_cnt[1][2] !== 3'(3 - i)) begin errors++;
            $display("FAIL fill_cnt step=%0d got=%0d exp=%0d", i, u_if.credit_cnt[1][2], 3 - i); end
         checks++; if (u_if.vc_free[1][2] !== 1'b0) begin errors++;
            $display("FAIL fill_vc_free step=%0d got=%b exp=0", i, u_if.vc_free[1][2]); end
      end
      checks++; if (u_if.credit_avail !== 16'hFFBF) begin errors++;
         $display("FAIL fill_avail got=%h exp=ffbf", u_if.credit_avail); end
      for (int i = 0; i < 4; i++) begin
         u_if.in_credit[1][2] = 1'b1;
         tick(); idle_inputs();
      end
      checks++; if (u_if.credit_cnt[1][2] !== 3'd4 || u_if.vc_free[1][2] !== 1'b0) begin errors++;
         $display("FAIL fill_refill got cnt=%0d free=%b exp cnt=4 free=0",
                  u_if.credit_cnt[1][2], u_if.vc_free[1][2]); end
      // tail sent with a same-cycle credit at full count: straight back to IDLE
      drive_send(1, 2, 1'b1);
      u_if.in_credit[1][2] = 1'b1;
      tick(); idle_inputs();
      checks++; if (u_if.credit_cnt[1][2] !== 3'd4 || u_if.vc_free[1][2] !== 1'b1) begin errors++;
         $display("FAIL fill_tail_direct got cnt=%0d free=%b exp cnt=4 free=1",
                  u_if.credit_cnt[1][2], u_if.vc_free[1][2]); end
   endtask

   task automatic test_tail_drain;
      u_if.alloc_valid[0][1] = 1'b1;
      tick(); idle_inputs();
      drive_send(0, 1, 1'b0);
      tick(); idle_inputs();
      drive_send(0, 1, 1'b1);
      tick(); idle_inputs();
      checks++; if (u_if.credit_cnt[0][1] !== 3'd2 || u_if.vc_free[0][1] !== 1'b0) begin errors++;
         $display("FAIL drain_after_tail got cnt=%0d free=%b exp cnt=2 free=0",
                  u_if.credit_cnt[0][1], u_if.vc_free[0][1]); end
      u_if.in_credit[0][1] = 1'b1;
      tick(); idle_inputs();
      checks++; if (u_if.credit_cnt[0][1] !== 3'd3 || u_if.vc_free[0][1] !== 1'b0) begin errors++;
         $display("FAIL drain_credit1 got cnt=%0d free=%b exp cnt=3 free=0",
                  u_if.credit_cnt[0][1], u_if.vc_free[0][1]); end
      u_if.in_credit[0][1] = 1'b1;
      tick(); idle_inputs();
      checks++; if (u_if.credit_cnt[0][1] !== 3'd4 || u_if.vc_free[0][1] !== 1'b1) begin errors++;
         $display("FAIL drain_credit2 got cnt=%0d free=%b exp cnt=4 free=1",
                  u_if.credit_cnt[0][1], u_if.vc_free[0][1]); end
   endtask

   task automatic test_same_cycle;
      u_if.alloc_valid[3][0] = 1'b1;
      tick(); idle_inputs();
      for (int i = 0; i < 4; i++) begin
         drive_send(3, 0, 1'b0);
         tick(); idle_inputs();
      end
      checks++; if (u_if.credit_cnt[3][0] !== 3'd0 || u_if.credit_avail[3][0] !== 1'b0) begin errors++;
         $display("FAIL same_empty got cnt=%0d avail=%b exp cnt=0 avail=0",
                  u_if.credit_cnt[3][0], u_if.credit_avail[3][0]); end
      drive_send(3, 0, 1'b0);
      u_if.in_credit[3][0] = 1'b1;
      tick(); idle_inputs();
      checks++; if (u_if.credit_cnt[3][0] !== 3'd0 || u_if.credit_err !== 16'h0000) begin errors++;
         $display("FAIL same_at_zero got cnt=%0d err=%h exp cnt=0 err=0000",
                  u_if.credit_cnt[3][0], u_if.credit_err); end
      for (int i = 0; i < 4; i++) begin
         u_if.in_credit[3][0] = 1'b1;
         tick(); idle_inputs();
      end
      drive_send(3, 0, 1'b0);
      u_if.in_credit[3][0] = 1'b1;
      tick(); idle_inputs();
      checks++; if (u_if.credit_cnt[3][0] !== 3'd4 || u_if.credit_err !== 16'h0000) begin errors++;
         $display("FAIL same_at_full got cnt=%0d err=%h exp cnt=4 err=0000",
                  u_if.credit_cnt[3][0], u_if.credit_err); end
      drive_send(3, 0, 1'b1);
      tick(); idle_inputs();
      u_if.in_credit[3][0] = 1'b1;
      tick(); idle_inputs();
      checks++; if (u_if.credit_cnt[3][0] !== 3'd4 || u_if.vc_free[3][0] !== 1'b1) begin errors++;
         $display("FAIL same_release got cnt=%0d free=%b exp cnt=4 free=1",
                  u_if.credit_cnt[3][0], u_if.vc_free[3][0]); end
   endtask

`ifdef OUT_VC_CREDIT_ERR_CHK_EN
   task automatic test_err_chk;
      u_if.in_credit[2][3] = 1'b1;
      tick(); idle_inputs();
      checks++; if (u_if.credit_cnt[2][3] !== 3'd4 || u_if.credit_err !== 16'h0800) begin errors++;
         $display("FAIL err_overflow got cnt=%0d err=%h exp cnt=4 err=0800",
                  u_if.credit_cnt[2][3], u_if.credit_err); end
      for (int i = 0; i < 10; i++) tick();
      checks++; if (u_if.credit_err[2][3] !== 1'b1) begin errors++;
         $display("FAIL err_sticky got=%b exp=1", u_if.credit_err[2][3]); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      checks++; if (u_if.credit_err !== 16'h0000 || u_if.credit_cnt !== {16{3'd4}}) begin errors++;
         $display("FAIL err_reset got err=%h cnt=%h exp err=0000 cnt=all 4",
                  u_if.credit_err, u_if.credit_cnt); end
   endtask
`else
   task automatic test_wrap;
      u_if.in_credit[2][3] = 1'b1;
      tick(); idle_inputs();
      checks++; if (u_if.credit_cnt[2][3] !== 3'd5 || u_if.credit_err !== 16'h0000) begin errors++;
         $display("FAIL wrap_overflow got cnt=%0d err=%h exp cnt=5 err=0000",
                  u_if.credit_cnt[2][3], u_if.credit_err); end
      drive_send(2, 3, 1'b0);
      tick(); idle_inputs();
      checks++; if (u_if.credit_cnt[2][3] !== 3'd4 || u_if.vc_free[2][3] !== 1'b1) begin errors++;
         $display("FAIL idle_dec got cnt=%0d free=%b exp cnt=4 free=1",
                  u_if.credit_cnt[2][3], u_if.vc_free[2][3]); end
   endtask
`endif

   task automatic test_back_to_back;
      int m [4];
      int vv;
      logic s, c;
      logic [3:0][3:0][2:0] exp_cnt;
      logic [3:0][3:0]      exp_avail;
      for (int p = 0; p < 4; p++) begin
         m[p] = 4;
         u_if.alloc_valid[p][(p + 1) % 4] = 1'b1;
      end
      tick(); idle_inputs();
      checks++; if (u_if.vc_free !== 16'hE7BD) begin errors++;
         $display("FAIL b2b_alloc got=%h exp=e7bd", u_if.vc_free); end
      for (int cyc = 0; cyc < 40; cyc++) begin
         for (int p = 0; p < 4; p++) begin
            vv = (p + 1) % 4;
            s  = ($urandom_range(0, 1) == 1) && (m[p] > 0);
            c  = ($urandom_range(0, 2) != 0) && ((4 - m[p] + (s ? 1 : 0)) > 0);
            if (s) drive_send(p, vv, 1'b0);
            u_if.in_credit[p][vv] = c;
            if (s && !c) m[p] = m[p] - 1;
            if (c && !s) m[p] = m[p] + 1;
         end
         tick(); idle_inputs();
         exp_cnt   = {16{3'd4}};
         exp_avail = 16'hFFFF;
         for (int p = 0; p < 4; p++) begin
            exp_cnt[p][(p + 1) % 4]   = 3'(m[p]);
            exp_avail[p][(p + 1) % 4] = (m[p] != 0);
         end
         checks++; if (u_if.credit_cnt !== exp_cnt) begin errors++;
            $display("FAIL b2b_cnt cyc=%0d got=%h exp=%h", cyc, u_if.credit_cnt, exp_cnt); end
         checks++; if (u_if.credit_avail !== exp_avail) begin errors++;
            $display("FAIL b2b_avail cyc=%0d got=%h exp=%h", cyc, u_if.credit_avail, exp_avail); end
      end
      checks++; if (u_if.vc_free !== 16'hE7BD) begin errors++;
         $display("FAIL b2b_still_owned got=%h exp=e7bd", u_if.vc_free); end
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_fill();
      test_tail_drain();
      test_same_cycle();
`ifdef OUT_VC_CREDIT_ERR_CHK_EN
      test_err_chk();
`else
      test_wrap();
`endif
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/out_vc_credit_tracker.md
Name: out_vc_credit_tracker

Overview:
- Sits directly downstream of ctrl_web inside each router.
- Consumes the per-port, per-VC credit-return pulses that ctrl_web delivers on in_credit.
- Keeps a per-output-port, per-VC credit count of free buffer slots in the neighbour router's input VCs.
- Runs a per-VC state machine that tells the VC/switch allocators which downstream VCs may take a new packet and which may send a flit this cycle.

Parameters:
- NUM_OUT, default NUM_PORTS-1 (4): mesh output ports, order {W,S,E,N} = index {3,2,1,0}. The local port is excluded.
- NUM_VCS, default router_pkg NUM_VCS (4): virtual channels per port.
- BUF_DEPTH, default 4: flit slots per downstream input VC, which is also the initial credit count.
- CNT_W, default $clog2(BUF_DEPTH+1): credit counter width.

Ports:
- clk  in  1  router clock.
- rst_n  in  1  reset; synchronous, active-low.
- in_credit  in  [NUM_OUT][NUM_VCS] x 1  one-cycle credit-return pulse per port/VC, from ctrl_web.
- alloc_valid  in  [NUM_OUT][NUM_VCS] x 1  VC allocator grants output VC (p,v) to a head flit.
- send_valid  in  [NUM_OUT] x 1  switch traversal of one flit on port p this cycle.
- send_vc  in  [NUM_OUT] x $clog2(NUM_VCS)  output VC of the flit sent on port p.
- send_tail  in  [NUM_OUT] x 1  the sent flit is a tail (or head+tail single-flit packet).
- vc_free  out  [NUM_OUT][NUM_VCS] x 1  VC (p,v) is IDLE and allocatable.
- credit_avail  out  [NUM_OUT][NUM_VCS] x 1  credit count (p,v) > 0.
- credit_cnt  out  [NUM_OUT][NUM_VCS] x CNT_W  current credit count.
- credit_err  out  [NUM_OUT][NUM_VCS] x 1  sticky overflow/underflow flag (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - every credit_cnt = BUF_DEPTH;
  - every VC state = IDLE;
  - vc_free = all 1;
  - credit_avail = all 1;
  - credit_err = all 0.
  - A mid-operation reset discards all in-flight state identically.
- Counter update per (p,v), registered; the new value is visible on the cycle after the event:
  - dec = send_valid[p] && send_vc[p]==v; inc = in_credit[p][v].
  - inc only: cnt+1. dec only: cnt-1. Both: cnt unchanged. Neither: hold.
- credit_avail and vc_free are combinational decodes of registered state. They have no input-to-output combinational path.
- VC FSM per (p,v):
  - IDLE -> ACTIVE on alloc_valid[p][v].
  - ACTIVE -> WAIT_CREDITS on dec with send_tail[p]=1.
  - WAIT_CREDITS -> IDLE when the next-state count == BUF_DEPTH. This includes the same cycle a final credit arrives.
  - If the tail is sent and the count is already BUF_DEPTH after the update (impossible unless the credit is returned the same cycle), the transition is ACTIVE -> IDLE directly.
  - Atomic VC reuse: a VC is never reallocated until the downstream buffer is fully drained.
- Illegal inputs:
  - alloc_valid while not IDLE: ignored.
  - dec while IDLE or WAIT_CREDITS: counted; flagged under the optional feature.
  - dec with cnt==0 is underflow; inc with cnt==BUF_DEPTH is overflow.
- Boundaries:
  - cnt==0 drives credit_avail=0; the allocator must not send.
  - A credit arriving on the same cycle as a dec with cnt==0 is legal: the count stays 0 and no error is raised.
- Ports and VCs are fully independent, with no cross-port interaction.

Optional Feature:
- Macro: OUT_VC_CREDIT_ERR_CHK_EN.
- Defined:
  - Underflow saturates at 0 and overflow saturates at BUF_DEPTH.
  - Either event sets credit_err[p][v]. The flag is sticky until reset.
  - Simulation assertions also fire on alloc_valid to a non-IDLE VC.
- Undefined:
  - credit_err is tied to 0.
  - Counters wrap modulo 2^CNT_W.
  - No assertions are compiled.

Test Plan:
- Reset, BUF_DEPTH=4 -> all credit_cnt=4, vc_free=1, credit_avail=1, credit_err=0 on the first cycle after rst_n rises.
- Port 1 / VC 2: alloc, then 4 body flits with no credits back -> cnt 4,3,2,1,0; credit_avail[1][2]=0 after the 4th send; vc_free[1][2]=0 throughout.
- Port 0 / VC 1: send tail at cnt=2, then return 2 credits on consecutive cycles -> state WAIT_CREDITS; vc_free[0][1] rises the cycle after the second credit; cnt=4.
- Port 3 / VC 0: send and credit in the same cycle at cnt=0 -> cnt stays 0, credit_err=0; at cnt=4 -> cnt stays 4, no error.
- With OUT_VC_CREDIT_ERR_CHK_EN, in_credit pulse on port 2 / VC 3 at cnt=4 -> cnt stays 4, credit_err[2][3]=1 and still 1 ten cycles later; rst_n low one cycle -> clears to 0.
- All four ports sending simultaneously on different VCs with interleaved credit pulses -> each counter matches an independent scoreboard model every cycle; no cross-talk.
